// File: rtl/cvp14_core_if.sv
// cvp14_core_if: memory bus between the co-processor and the unified DRAM.
//   Addr    - word address driven by the core
//   RD/WR   - read / write request (never both high)
//   DataOut - write data driven by the core
//   DataIn  - read data from DRAM, valid the cycle after RD
//   V       - sticky signed-overflow flag exported by the core
interface cvp14_core_if;
    logic [15:0] Addr;
    logic        RD;
    logic        WR;
    logic [15:0] DataOut;
    logic [15:0] DataIn;
    logic        V;

    modport master (output Addr, output RD, output WR, output DataOut, output V, input DataIn);
    modport slave  (input Addr, input RD, input WR, input DataOut, input V, output DataIn);
endinterface

// File: rtl/cvp14_core.sv
// cvp14_core: 16-bit vector co-processor with 8 scalar and 8 vector registers
// (16 x 16-bit elements each). Instructions and data share one DRAM port.
//   Clk1  - system clock, rising edge
//   Reset - synchronous, active-low
//   bus   - cvp14_core_if master: Addr/RD/WR/DataOut/V out, DataIn in
module cvp14_core #(
    parameter int NUM_ELEM = 16,
    parameter int NUM_REGS = 8
) (
    input logic           Clk1,
    input logic           Reset,
    cvp14_core_if.master  bus
);

    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

    localparam logic [3:0] OP_VADD = 4'h0;
    localparam logic [3:0] OP_VDOT = 4'h1;
    localparam logic [3:0] OP_SMUL = 4'h2;
    localparam logic [3:0] OP_SLL  = 4'h3;
    localparam logic [3:0] OP_SLH  = 4'h4;
    localparam logic [3:0] OP_VLD  = 4'h5;
    localparam logic [3:0] OP_VST  = 4'h6;
    localparam logic [3:0] OP_SLD  = 4'h7;
    localparam logic [3:0] OP_SST  = 4'h8;
    localparam logic [3:0] OP_J    = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t      state, state_nxt;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [4:0]  step;      // EXEC sub-cycle; bit 4 marks the tail cycle of VLD/VDOT
    logic [15:0] acc;       // VDOT running sum
    logic        v_flag;

    logic [NUM_REGS-1:0][15:0]               sreg;
    logic [NUM_REGS-1:0][NUM_ELEM-1:0][15:0] vreg;

    // instruction fields
    logic [3:0]  op;
    logic [2:0]  ra, rb, rc;
    logic [7:0]  imm8;
    logic [15:0] base, ea;
    logic [3:0]  elem, elem_prev;
    logic [4:0]  last_step;
    logic        exec_done;

    assign op        = instr[15:12];
    assign ra        = instr[11:9];
    assign rb        = instr[8:6];
    assign rc        = instr[5:3];
    assign imm8      = instr[7:0];
    assign elem      = step[3:0];
    assign elem_prev = step[3:0] - 4'd1;   // VLD writes the element requested last cycle
    assign base      = sreg[rb] + {10'd0, instr[5:0]};
    assign ea        = base + {12'd0, elem};

    always_comb begin
        last_step = 5'd0;
        case (op)
            OP_VLD, OP_VDOT:          last_step = 5'd16;
            OP_VST, OP_VADD, OP_SMUL: last_step = 5'd15;
            OP_SLD:                   last_step = 5'd1;
            default:                  last_step = 5'd0;
        endcase
    end
    assign exec_done = (step == last_step);

    // element datapath
    logic [15:0]        vb, vc, sum, dsum;
    logic signed [31:0] smul_p, dot_p;
    logic               add_ovf, smul_ovf, dot_ovf;

    assign vb     = vreg[rb][elem];
    assign vc     = vreg[rc][elem];
    assign sum    = vb + vc;
    assign smul_p = $signed(sreg[rb]) * $signed(vc);
    assign dot_p  = $signed(vb) * $signed(vc);
    assign dsum   = acc + dot_p[15:0];

    assign add_ovf  = (vb[15] == vc[15]) && (sum[15] != vb[15]);
    assign smul_ovf = (smul_p[31:15] != {17{smul_p[15]}});
    // product overflow, or the partial sum with the truncated product overflows
    assign dot_ovf  = (dot_p[31:15] != {17{dot_p[15]}}) ||
                      ((acc[15] == dot_p[15]) && (dsum[15] != acc[15]));

    // state register
    always_ff @(posedge Clk1) begin
        if (!Reset) state <= S_FETCH;
        else        state <= state_nxt;
    end

    // next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                if (op == OP_HALT)  state_nxt = S_HALT;
                else if (exec_done) state_nxt = S_FETCH;
            end
            default:  state_nxt = S_HALT;
        endcase
    end

    // bus outputs; everything held low while in reset
    always_comb begin
        bus.Addr    = 16'd0;
        bus.RD      = 1'b0;
        bus.WR      = 1'b0;
        bus.DataOut = 16'd0;
        if (Reset) begin
            case (state)
                S_FETCH: begin
                    bus.Addr = pc;
                    bus.RD   = 1'b1;
                end
                S_EXEC: begin
                    case (op)
                        OP_VLD: if (!step[4]) begin
                            bus.Addr = ea;
                            bus.RD   = 1'b1;
                        end
                        OP_VST: begin
                            bus.Addr    = ea;
                            bus.WR      = 1'b1;
                            bus.DataOut = vreg[ra][elem];
                        end
                        OP_SLD: if (step == 5'd0) begin
                            bus.Addr = base;
                            bus.RD   = 1'b1;
                        end
                        OP_SST: begin
                            bus.Addr    = base;
                            bus.WR      = 1'b1;
                            bus.DataOut = sreg[ra];
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.V = v_flag;

    // datapath and architectural state
    always_ff @(posedge Clk1) begin
        if (!Reset) begin
            pc     <= 16'd0;
            instr  <= 16'd0;
            step   <= 5'd0;
            acc    <= 16'd0;
            v_flag <= 1'b0;
            sreg   <= '0;
            vreg   <= '0;
        end else begin
            case (state)
                S_DECODE: begin
                    instr <= bus.DataIn;
                    pc    <= pc + 16'd1;
                    step  <= 5'd0;
                    acc   <= 16'd0;
                end
                S_EXEC: begin
                    step <= step + 5'd1;
                    case (op)
                        OP_VADD: begin
                            vreg[ra][elem] <= sum;
                            if (add_ovf) v_flag <= 1'b1;
                        end
                        OP_VDOT: begin
                            if (!step[4]) begin
                                acc <= dsum;
                                if (dot_ovf) v_flag <= 1'b1;
                            end else begin
                                sreg[ra] <= acc;
                            end
                        end
                        OP_SMUL: begin
                            vreg[ra][elem] <= smul_p[15:0];
                            if (smul_ovf) v_flag <= 1'b1;
                        end
                        OP_SLL: sreg[ra][7:0]  <= imm8;
                        OP_SLH: sreg[ra][15:8] <= imm8;
                        OP_VLD: if (step != 5'd0) vreg[ra][elem_prev] <= bus.DataIn;
                        OP_SLD: if (step == 5'd1) sreg[ra] <= bus.DataIn;
                        // pc already points past the jump
                        OP_J:   pc <= pc + {{4{instr[11]}}, instr[11:0]};
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cvp14_core.sv
module tb_cvp14_core;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cvp14_core_if bus();

    cvp14_core dut (
        .Clk1  (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    // DRAM model with a bench-side load port used only while the core is idle
    logic [15:0] mem [0:65535];
    logic        ld_en = 1'b0;
    logic [15:0] ld_addr = 16'd0;
    logic [15:0] ld_data = 16'd0;
    int          wr_cnt = 0;

    always @(posedge clk) begin
        if (bus.WR) begin
            mem[bus.Addr] <= bus.DataOut;
            wr_cnt        <= wr_cnt + 1;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
        if (bus.RD) bus.DataIn <= mem[bus.Addr];
    end

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] sb[$];   // expected writes {addr, data} in issue order

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.WR) begin
            logic [31:0] exp;
            if (sb.size() != 0) exp = sb.pop_front();
            else                exp = 32'hFFFF_FFFF;
            chk("mem_write", {bus.Addr, bus.DataOut}, exp);
        end
    end

    function automatic logic [15:0] rrr(input logic [3:0] op, input int a, input int b, input int c);
        logic [2:0] a3, b3, c3;
        a3 = a[2:0]; b3 = b[2:0]; c3 = c[2:0];
        return {op, a3, b3, c3, 3'b000};
    endfunction

    function automatic logic [15:0] im8(input logic [3:0] op, input int a, input logic [7:0] imm);
        logic [2:0] a3;
        a3 = a[2:0];
        return {op, a3, 1'b0, imm};
    endfunction

    function automatic logic [15:0] im6(input logic [3:0] op, input int a, input int b, input logic [5:0] imm);
        logic [2:0] a3, b3;
        a3 = a[2:0]; b3 = b[2:0];
        return {op, a3, b3, imm};
    endfunction

    localparam logic [15:0] HALT = 16'hF000;

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_rst_rd"}, bus.RD, 0);
        chk({tag, "_rst_wr"}, bus.WR, 0);
        chk({tag, "_rst_addr"}, bus.Addr, 0);
        chk({tag, "_rst_v"}, bus.V, 0);
        chk({tag, "_rst_pc"}, dut.pc, 0);
    endtask

    task automatic wait_halt(input string tag, input int max_cyc);
        int n = 0;
        while (int'(dut.state) != 3 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_halted"}, int'(dut.state), 3);
    endtask

    task automatic run_prog(input string tag, input int max_cyc);
        @(negedge clk);
        rst_n = 1'b1;
        wait_halt(tag, max_cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- test 1: scalar byte loads and HALT
        do_reset("t1");
        poke(16'd0, im8(4'h3, 0, 8'h34));
        poke(16'd1, im8(4'h4, 0, 8'h12));
        poke(16'd2, HALT);
        run_prog("t1", 100);
        chk("t1_s0", dut.sreg[0], 16'h1234);
        chk("t1_pc", dut.pc, 16'd3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t1_halt_rdwr", {bus.RD, bus.WR}, 2'b00);
        end
        chk("t1_pc_frozen", dut.pc, 16'd3);

        // ---- test 2: VLD / VADD / VST / VDOT / SMUL
        do_reset("t2");
        for (int i = 0; i < 16; i++) poke(16'h0100 + 16'(i), 16'(i + 1));
        poke(16'd0, im8(4'h3, 1, 8'h00));
        poke(16'd1, im8(4'h4, 1, 8'h01));
        poke(16'd2, im6(4'h5, 1, 1, 6'd0));
        poke(16'd3, im6(4'h5, 2, 1, 6'd0));
        poke(16'd4, rrr(4'h0, 4, 1, 2));
        poke(16'd5, im6(4'h6, 4, 1, 6'h20));
        poke(16'd6, rrr(4'h1, 7, 1, 1));
        poke(16'd7, im8(4'h3, 0, 8'd2));
        poke(16'd8, rrr(4'h2, 3, 0, 1));
        poke(16'd9, HALT);
        for (int i = 0; i < 16; i++) sb.push_back({16'h0120 + 16'(i), 16'(2 * (i + 1))});
        run_prog("t2", 1000);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t2_v4[%0d]", i), dut.vreg[4][i], 16'(2 * (i + 1)));
            chk($sformatf("t2_v3[%0d]", i), dut.vreg[3][i], 16'(2 * (i + 1)));
            chk($sformatf("t2_mem[%0h]", 16'h0120 + 16'(i)), mem[16'h0120 + 16'(i)], 16'(2 * (i + 1)));
        end
        chk("t2_s7_vdot", dut.sreg[7], 16'd1496);
        chk("t2_v_flag", bus.V, 0);
        chk("t2_sb_empty", sb.size(), 0);

        // ---- test 3: overflow stickiness, J, SST/SLD
        do_reset("t3");
        for (int i = 0; i < 16; i++) begin
            poke(16'h0200 + 16'(i), 16'h7FFF);
            poke(16'h0210 + 16'(i), 16'h0001);
        end
        poke(16'd0, im8(4'h3, 1, 8'h00));
        poke(16'd1, im8(4'h4, 1, 8'h02));
        poke(16'd2, im6(4'h5, 1, 1, 6'h00));
        poke(16'd3, im6(4'h5, 2, 1, 6'h10));
        poke(16'd4, rrr(4'h0, 3, 1, 2));
        poke(16'd5, im8(4'h3, 2, 8'd5));
        poke(16'd6, rrr(4'h0, 4, 2, 2));
        poke(16'd7, 16'h9001);               // J +1: skip address 8
        poke(16'd8, im8(4'h3, 3, 8'hFF));
        poke(16'd9, im6(4'h8, 2, 1, 6'h30));
        poke(16'd10, im6(4'h7, 4, 1, 6'h30));
        poke(16'd11, HALT);
        sb.push_back({16'h0230, 16'd5});
        run_prog("t3", 1000);
        for (int i = 0; i < 16; i += 5) chk($sformatf("t3_v3[%0d]", i), dut.vreg[3][i], 16'h8000);
        chk("t3_v4[0]", dut.vreg[4][0], 16'd2);
        chk("t3_v_sticky", bus.V, 1);
        chk("t3_s3_skipped", dut.sreg[3], 16'd0);
        chk("t3_s4_sld", dut.sreg[4], 16'd5);
        chk("t3_mem230", mem[16'h0230], 16'd5);
        chk("t3_pc", dut.pc, 16'd12);
        chk("t3_sb_empty", sb.size(), 0);

        // ---- test 4: reset after the fifth VST write
        do_reset("t4");
        for (int i = 0; i < 16; i++) begin
            poke(16'h0300 + 16'(i), 16'hA000 + 16'(i));
            poke(16'h0320 + 16'(i), 16'hDEAD);
        end
        poke(16'd0, im8(4'h3, 1, 8'h00));
        poke(16'd1, im8(4'h4, 1, 8'h03));
        poke(16'd2, im6(4'h5, 1, 1, 6'h00));
        poke(16'd3, im6(4'h6, 1, 1, 6'h20));
        poke(16'd4, HALT);
        for (int i = 0; i < 5; i++) sb.push_back({16'h0320 + 16'(i), 16'hA000 + 16'(i)});
        begin
            int wr_base;
            int n;
            wr_base = wr_cnt;
            n = 0;
            @(negedge clk);
            rst_n = 1'b1;
            while (wr_cnt - wr_base < 5 && n < 500) begin
                @(posedge clk);
                #1;
                n++;
            end
            rst_n = 1'b0;
            chk("t4_five_writes", wr_cnt - wr_base, 5);
        end
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 16; i++)
            chk($sformatf("t4_mem[%0h]", 16'h0320 + 16'(i)), mem[16'h0320 + 16'(i)],
                (i < 5) ? 16'hA000 + 16'(i) : 16'hDEAD);
        chk("t4_pc", dut.pc, 16'd0);
        chk("t4_s1_clr", dut.sreg[1], 16'd0);
        chk("t4_v1_clr", dut.vreg[1][3], 16'd0);
        chk("t4_sb_empty", sb.size(), 0);
        poke(16'd3, HALT);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t4_restart_addr", bus.Addr, 16'd0);
        chk("t4_restart_rd", bus.RD, 1);
        wait_halt("t4", 1000);
        chk("t4_s1_rerun", dut.sreg[1], 16'h0300);
        chk("t4_pc_end", dut.pc, 16'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
